// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing the ddr_controller burst port among NREQ cache requesters.
// One burst in flight; beats, write-data strobes and completion are routed to the granted requester only.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no burst; choose next requester once calibration is complete
// S_BURST | grant held, burst request high until its matching finish
// S_DONE  | one-cycle completion pulse to the requester just served
module ddr_burst_arbiter #(
    parameter int NREQ           = 4,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               calib_done,
    input  logic [NREQ-1:0]                    req,
    input  logic [NREQ-1:0]                    req_we,
    input  logic [NREQ*DDR_ADDR_WIDTH-1:0]     req_addr,
    input  logic [NREQ*LEN_WIDTH-1:0]          req_len,
    input  logic [NREQ*DDR_DATA_WIDTH-1:0]     req_wdata,
    output logic [NREQ-1:0]                    grant,
    output logic [NREQ-1:0]                    done,
    output logic [NREQ-1:0]                    rd_valid,
    output logic [NREQ-1:0]                    wr_data_req,
    output logic [DDR_DATA_WIDTH-1:0]          rd_data,
    output logic                               rd_burst_req,
    output logic                               wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
    output logic [LEN_WIDTH-1:0]               rd_burst_len,
    output logic [LEN_WIDTH-1:0]               wr_burst_len,
    output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data,
    input  logic                               rd_burst_data_valid,
    input  logic                               wr_burst_data_req,
    input  logic                               rd_burst_finish,
    input  logic                               wr_burst_finish,
    input  logic [DDR_DATA_WIDTH-1:0]          rd_burst_data,
    output logic                               busy,
    output logic                               len_err
);

    localparam int AW = DDR_ADDR_WIDTH;
    localparam int DW = DDR_DATA_WIDTH;
    localparam int LW = LEN_WIDTH;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic            win_found;
    logic [AW-1:0]   pick_addr;
    logic [LW-1:0]   pick_len;
    logic [AW-1:0]   lat_addr;
    logic [LW-1:0]   lat_len;
    logic            lat_we;
    logic [LW:0]     beat_cnt;
    logic [LW:0]     beat_nxt;
    logic            strobe;
    logic            in_range;
    logic            finish_hit;
    logic            fwd;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_addr = req_addr[int'(win_idx)*AW +: AW];
        pick_len  = req_len[int'(win_idx)*LW +: LW];
    end

    // Beats past the latched length are counted (for len_err) but never forwarded.
    assign strobe     = lat_we ? wr_burst_data_req : rd_burst_data_valid;
    assign finish_hit = lat_we ? wr_burst_finish : rd_burst_finish;
    assign in_range   = beat_cnt < {1'b0, lat_len};
    assign beat_nxt   = (strobe && !(&beat_cnt)) ? beat_cnt + 1'b1 : beat_cnt;
    assign fwd        = (state == S_BURST) && in_range;

    assign rd_valid    = (fwd && !lat_we && rd_burst_data_valid) ? grant : '0;
    assign wr_data_req = (fwd &&  lat_we && wr_burst_data_req)   ? grant : '0;
    assign rd_data     = rd_burst_data;
    assign busy        = (state != S_IDLE);

    assign rd_burst_addr = lat_addr;
    assign wr_burst_addr = lat_addr;
    assign rd_burst_len  = lat_len;
    assign wr_burst_len  = lat_len;

    always_comb begin
        wr_burst_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                wr_burst_data = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ptr          <= PW'(NREQ - 1);
            gidx         <= '0;
            grant        <= '0;
            done         <= '0;
            rd_burst_req <= 1'b0;
            wr_burst_req <= 1'b0;
            lat_addr     <= '0;
            lat_len      <= '0;
            lat_we       <= 1'b0;
            beat_cnt     <= '0;
            len_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    if (calib_done && win_found) begin
                        grant          <= '0;
                        grant[win_idx] <= 1'b1;
                        gidx           <= win_idx;
                        lat_addr       <= pick_addr;
                        lat_len        <= pick_len;
                        lat_we         <= req_we[win_idx];
                        beat_cnt       <= '0;
                        rd_burst_req   <= (pick_len != '0) && !req_we[win_idx];
                        wr_burst_req   <= (pick_len != '0) &&  req_we[win_idx];
                        state          <= S_BURST;
                    end
                end
                S_BURST: begin
                    beat_cnt <= beat_nxt;
                    // Zero-length requests complete without ever touching the controller.
                    if (lat_len == '0) begin
                        done  <= grant;
                        grant <= '0;
                        ptr   <= gidx;
                        state <= S_DONE;
                    end else if (finish_hit) begin
                        done         <= grant;
                        grant        <= '0;
                        ptr          <= gidx;
                        rd_burst_req <= 1'b0;
                        wr_burst_req <= 1'b0;
                        if (beat_nxt != {1'b0, lat_len}) begin
                            len_err <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Scoreboard bench for ddr_burst_arbiter: a round-robin reference model queues expected grants
// and completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ddr_burst_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 128;
    localparam int AW   = 28;
    localparam int LW   = 10;

    logic                  clk;
    logic                  rst_n;
    logic                  calib_done;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*LW-1:0]    req_len;
    logic [NREQ*DW-1:0]    req_wdata;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       rd_valid;
    logic [NREQ-1:0]       wr_data_req;
    logic [DW-1:0]         rd_data;
    logic                  rd_burst_req;
    logic                  wr_burst_req;
    logic [AW-1:0]         rd_burst_addr;
    logic [AW-1:0]         wr_burst_addr;
    logic [LW-1:0]         rd_burst_len;
    logic [LW-1:0]         wr_burst_len;
    logic [DW-1:0]         wr_burst_data;
    logic                  rd_burst_data_valid;
    logic                  wr_burst_data_req;
    logic                  rd_burst_finish;
    logic                  wr_burst_finish;
    logic [DW-1:0]         rd_burst_data;
    logic                  busy;
    logic                  len_err;

    ddr_burst_arbiter #(
        .NREQ(NREQ), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rd_valid(rd_valid), .wr_data_req(wr_data_req), .rd_data(rd_data),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .wr_burst_data(wr_burst_data),
        .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
        .rd_burst_data(rd_burst_data),
        .busy(busy), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int idx; logic [AW-1:0] addr; logic [LW-1:0] len; logic we; } grant_t;
    typedef struct { int idx; int fwd; logic err; } done_t;

    grant_t exp_grant[$];
    done_t  exp_done[$];
    int     errors = 0;
    int     checks = 0;

    logic [AW-1:0] t_addr [NREQ];
    logic [LW-1:0] t_len  [NREQ];
    logic [DW-1:0] t_wdata[NREQ];
    int            t_beats[NREQ];

    int            mptr = NREQ - 1;
    logic          merr = 1'b0;
    logic [DW-1:0] drv_data = '0;

    assign req_we = 4'b1000;

    always_comb begin
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = t_addr[i];
            req_len[i*LW +: LW]   = t_len[i];
            req_wdata[i*DW +: DW] = t_wdata[i];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: serve every pending requester in round-robin order starting after mptr.
    task automatic launch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        int c;
        int f;
        pend = mask;
        while (pend != '0) begin
            c = 0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (mptr + k) % NREQ;
                if (pend[c]) break;
            end
            exp_grant.push_back('{c, t_addr[c], t_len[c], (c == NREQ - 1)});
            if (t_len[c] == 0) f = 0;
            else f = (t_beats[c] < int'(t_len[c])) ? t_beats[c] : int'(t_len[c]);
            if (t_len[c] != 0 && t_beats[c] != int'(t_len[c])) merr = 1'b1;
            exp_done.push_back('{c, f, merr});
            pend[c] = 1'b0;
            mptr = c;
        end
        req = mask;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input int len, input int beats);
        t_addr[i]  = a;
        t_len[i]   = LW'(len);
        t_beats[i] = beats;
        t_wdata[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(exp_done.size() == 0 && req == '0 && !busy) && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles with %0d completions pending", n, exp_done.size());
            exp_grant.delete();
            exp_done.delete();
            req = '0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Requesters drop their request in the completion cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (done[i]) req[i] = 1'b0;
        end
    end

    // ddr_controller model: a stray opposite-type finish, then t_beats strobes with gaps, then finish.
    initial begin
        int g;
        logic we;
        rd_burst_data_valid = 1'b0;
        wr_burst_data_req   = 1'b0;
        rd_burst_finish     = 1'b0;
        wr_burst_finish     = 1'b0;
        rd_burst_data       = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && (rd_burst_req || wr_burst_req)) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (grant[i]) g = i;
                we = wr_burst_req;
                if (we) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
                @(posedge clk); #1;
                rd_burst_finish = 1'b0;
                wr_burst_finish = 1'b0;
                for (int b = 0; b < t_beats[g]; b++) begin
                    if (!rst_n) break;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    if (we) wr_burst_data_req = 1'b1;
                    else begin
                        drv_data            = {$urandom, $urandom, $urandom, $urandom};
                        rd_burst_data       = drv_data;
                        rd_burst_data_valid = 1'b1;
                    end
                    @(posedge clk); #1;
                    rd_burst_data_valid = 1'b0;
                    wr_burst_data_req   = 1'b0;
                end
                if (rst_n) begin
                    if (we) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
                    @(posedge clk); #1;
                    rd_burst_finish = 1'b0;
                    wr_burst_finish = 1'b0;
                end
            end
        end
    end

    // Monitor: compares grants, routed strobes and completions against the queued expectations.
    logic [NREQ-1:0] prev_grant = '0;
    grant_t          cur;
    logic            have_cur = 1'b0;
    int              fwd_cnt = 0;
    logic            mon_en = 1'b1;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (grant != '0 && prev_grant == '0) begin
                if (exp_grant.size() == 0) chk("unexpected_grant", DW'(grant), '0);
                else begin
                    cur      = exp_grant.pop_front();
                    have_cur = 1'b1;
                    fwd_cnt  = 0;
                    chk("grant", DW'(grant), DW'(1 << cur.idx));
                    chk("burst_addr", DW'(cur.we ? wr_burst_addr : rd_burst_addr), DW'(cur.addr));
                    chk("burst_len", DW'(cur.we ? wr_burst_len : rd_burst_len), DW'(cur.len));
                    chk("rd_burst_req", DW'(rd_burst_req), DW'(!cur.we && cur.len != 0));
                    chk("wr_burst_req", DW'(wr_burst_req), DW'(cur.we && cur.len != 0));
                end
            end
            if ((rd_valid | wr_data_req) != '0) begin
                fwd_cnt++;
                if (have_cur) begin
                    chk("rd_valid", DW'(rd_valid), cur.we ? '0 : DW'(1 << cur.idx));
                    chk("wr_data_req", DW'(wr_data_req), cur.we ? DW'(1 << cur.idx) : '0);
                    if (cur.we) chk("wr_burst_data", wr_burst_data, t_wdata[cur.idx]);
                    else        chk("rd_data", rd_data, drv_data);
                end
            end
            if (done != '0) begin
                if (exp_done.size() == 0) chk("unexpected_done", DW'(done), '0);
                else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("done", DW'(done), DW'(1 << d.idx));
                    chk("beats_forwarded", DW'(fwd_cnt), DW'(d.fwd));
                    chk("len_err", DW'(len_err), DW'(d.err));
                    chk("grant_cleared", DW'(grant), '0);
                    chk("burst_req_dropped", DW'({rd_burst_req, wr_burst_req}), '0);
                end
                have_cur = 1'b0;
            end
        end
        prev_grant = grant;
    end

    initial begin
        int n;
        rst_n      = 1'b1;
        calib_done = 1'b0;
        req        = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, '0, 0, 0);
        #1 rst_n = 1'b0;
        #3;
        chk("reset_grant", DW'(grant), '0);
        chk("reset_done", DW'(done), '0);
        chk("reset_busy", DW'(busy), '0);
        chk("reset_len_err", DW'(len_err), '0);
        chk("reset_burst_req", DW'({rd_burst_req, wr_burst_req}), '0);
        chk("reset_wr_burst_data", wr_burst_data, '0);
        @(negedge clk) rst_n = 1'b1;

        // No grant until calibration completes.
        set_req(0, 28'h100, 8, 8);
        @(posedge clk); #1;
        launch(4'b0001);
        repeat (5) @(posedge clk);
        #1;
        chk("no_grant_without_calib", DW'(grant), '0);
        calib_done = 1'b1;
        wait_idle(300);

        // All four requesting, then requester 0 alone after the wrap.
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(32'h1000 * (i + 1)), 4, 4);
        launch(4'b1111);
        wait_idle(600);
        launch(4'b0001);
        wait_idle(200);

        set_req(3, 28'h0abc00, 2, 2);
        launch(4'b1000);
        wait_idle(200);

        // calib_done falling mid-burst: burst completes, no new grant until it rises.
        set_req(0, 28'h2000, 6, 6);
        launch(4'b0001);
        n = 0;
        while (!busy && n < 20) begin @(posedge clk); n++; end
        #1 calib_done = 1'b0;
        wait_idle(200);
        set_req(1, 28'h3000, 3, 3);
        launch(4'b0010);
        repeat (6) @(posedge clk);
        #1;
        chk("no_grant_calib_low", DW'(grant), '0);
        calib_done = 1'b1;
        wait_idle(200);

        chk("len_err_clean", DW'(len_err), '0);
        set_req(2, 28'h4000, 4, 3);
        launch(4'b0100);
        wait_idle(200);
        set_req(1, 28'h5000, 0, 0);
        launch(4'b0010);
        wait_idle(200);
        set_req(1, 28'h6000, 3, 5);
        launch(4'b0010);
        wait_idle(200);

        // Asynchronous reset mid-burst.
        set_req(1, 28'h7000, 40, 40);
        launch(4'b0010);
        n = 0;
        while (rd_valid == '0 && n < 200) begin @(posedge clk); n++; end
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_grant", DW'(grant), '0);
        chk("rst_mid_busy", DW'(busy), '0);
        chk("rst_mid_burst_req", DW'({rd_burst_req, wr_burst_req}), '0);
        chk("rst_mid_rd_valid", DW'(rd_valid), '0);
        chk("rst_mid_len_err", DW'(len_err), '0);
        req = '0;
        exp_grant.delete();
        exp_done.delete();
        have_cur = 1'b0;
        mptr = NREQ - 1;
        merr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;

        set_req(0, 28'h8000, 2, 2);
        set_req(1, 28'h9000, 2, 2);
        launch(4'b0011);
        wait_idle(300);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int len;
                int v;
                len = $urandom_range(0, 6);
                v   = $urandom_range(0, 9);
                if (v == 0) set_req(i, AW'($urandom), len, len + 1);
                else if (v == 1 && len > 0) set_req(i, AW'($urandom), len, len - 1);
                else set_req(i, AW'($urandom), len, len);
            end
            launch(NREQ'($urandom_range(1, 15)));
            wait_idle(800);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
